alarm_ctrl: RTL

Alarm sequencing controller between the keypad alarm-entry datapath and the clock/LED outputs. Arms on a validated alarm time, detects the match against the running HH:MM clock, and drives a blinking ring pattern. Handles stop, bounded snooze with 24-hour BCD wrap, and ring timeout. Replaces free-running compare logic with an explicit armed/ringing/snooze state machine.

---
 rtl/alarm_pkg.sv | 40 ++++
 rtl/bcd_time_add.sv | 32 +++
 rtl/alarm_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencing controller.
// Holds the state encoding, LED patterns, BCD limits and the alarm-time validity check.
`timescale 1ns/1ps
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] h_ten;
        logic [3:0] h_one;
        logic [3:0] m_ten;
        logic [3:0] m_one;
    } bcd_time_t;

    localparam logic [7:0] LED_ON   = 8'hFF;
    localparam logic [7:0] LED_OFF  = 8'h00;
    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;

    // Digits above 9 are rejected before the hour/minute range is checked.
    function automatic logic time_valid(input bcd_time_t t);
        logic       ok;
        logic [7:0] hour;
        logic [7:0] minute;
        ok     = (t.h_ten <= 4'd9) && (t.h_one <= 4'd9) &&
                 (t.m_ten <= 4'd9) && (t.m_one <= 4'd9);
        hour   = {4'd0, t.h_ten} * 8'd10 + {4'd0, t.h_one};
        minute = {4'd0, t.m_ten} * 8'd10 + {4'd0, t.m_one};
        if (hour > HOUR_MAX || minute > MIN_MAX) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Combinational HH:MM BCD plus a fixed number of minutes, wrapping at 24 hours.
// The input time is assumed valid; ADD_MIN must be 1..59.
`timescale 1ns/1ps
module bcd_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  bcd_time_t i_time,
    output bcd_time_t o_time
);

    logic [7:0] w_min;
    logic [7:0] w_hour;

    always_comb begin
        w_min  = {4'd0, i_time.m_ten} * 8'd10 + {4'd0, i_time.m_one} + 8'(ADD_MIN);
        w_hour = {4'd0, i_time.h_ten} * 8'd10 + {4'd0, i_time.h_one};
        if (w_min > MIN_MAX) begin
            w_min  = w_min - 8'd60;
            w_hour = w_hour + 8'd1;
        end
        if (w_hour > HOUR_MAX) begin
            w_hour = 8'd0;
        end
        o_time.h_ten = 4'(w_hour / 8'd10);
        o_time.h_one = 4'(w_hour % 8'd10);
        o_time.m_ten = 4'(w_min / 8'd10);
        o_time.m_one = 4'(w_min % 8'd10);
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arms on a valid alarm entry, rings on a clock match, and handles
// stop, bounded snooze and ring timeout with a blinking LED pattern.
`timescale 1ns/1ps
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int MAX_SNOOZE     = 3,
    parameter int RING_TIMEOUT_S = 60,
    parameter int BLINK_CYC      = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sec_tick,
    input  logic [3:0] i_cur_h_ten,
    input  logic [3:0] i_cur_h_one,
    input  logic [3:0] i_cur_m_ten,
    input  logic [3:0] i_cur_m_one,
    input  logic [3:0] i_alm_h_ten,
    input  logic [3:0] i_alm_h_one,
    input  logic [3:0] i_alm_m_ten,
    input  logic [3:0] i_alm_m_one,
    input  logic       i_alarm_set_done,
    input  logic       i_arm_en,
    input  logic       i_snooze_btn,
    input  logic       i_stop_btn,
    output logic [1:0] o_state,
    output logic       o_ringing,
    output logic       o_armed,
    output logic [7:0] o_leds,
    output logic [1:0] o_snooze_cnt,
    output logic       o_set_err
);

    state_t     r_state;
    state_t     w_next;
    bcd_time_t  r_target;
    logic       r_match;
    logic       r_match_q;
    logic       r_snooze_q;
    logic       r_stop_q;
    logic [1:0] r_snooze_cnt;
    logic [7:0] r_ring_sec;
    logic [15:0] r_blink;
    logic [7:0] r_leds;
    logic       r_set_err;

    bcd_time_t  w_cur;
    bcd_time_t  w_alm;
    bcd_time_t  w_snz_time;
    logic       w_alm_valid;
    logic       w_load_try;
    logic       w_load_ok;
    logic       w_snz_edge;
    logic       w_stop_edge;
    logic       w_hit;
    logic       w_timeout;
    logic       w_snz_allowed;
    logic       w_reload;
    logic       w_snooze_go;
    logic       w_cnt_clr;

    assign w_cur         = {i_cur_h_ten, i_cur_h_one, i_cur_m_ten, i_cur_m_one};
    assign w_alm         = {i_alm_h_ten, i_alm_h_one, i_alm_m_ten, i_alm_m_one};
    assign w_alm_valid   = time_valid(w_alm);
    assign w_load_try    = i_alarm_set_done && (r_state != ST_RINGING);
    assign w_load_ok     = w_load_try && w_alm_valid;
    assign w_snz_edge    = i_snooze_btn & ~r_snooze_q;
    assign w_stop_edge   = i_stop_btn & ~r_stop_q;
    assign w_hit         = r_match & ~r_match_q;
    assign w_timeout     = i_sec_tick && (r_ring_sec == 8'(RING_TIMEOUT_S - 1));
    assign w_snz_allowed = r_snooze_cnt < 2'(MAX_SNOOZE);

    bcd_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snz_add (
        .i_time (w_cur),
        .o_time (w_snz_time)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In RINGING the arm switch beats stop, stop beats snooze, snooze beats timeout.
    always_comb begin
        w_next      = r_state;
        w_reload    = 1'b0;
        w_snooze_go = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_arm_en && w_load_ok) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!i_arm_en)  w_next = ST_IDLE;
                else if (w_hit) w_next = ST_RINGING;
            end
            ST_RINGING: begin
                if (!i_arm_en) begin
                    w_next    = ST_IDLE;
                    w_cnt_clr = 1'b1;
                end else if (w_stop_edge) begin
                    w_next   = ST_ARMED;
                    w_reload = 1'b1;
                end else if (w_snz_edge && w_snz_allowed) begin
                    w_next      = ST_SNOOZE;
                    w_snooze_go = 1'b1;
                end else if (w_timeout) begin
                    w_next   = ST_ARMED;
                    w_reload = 1'b1;
                end
            end
            ST_SNOOZE: begin
                if (!i_arm_en) begin
                    w_next = ST_IDLE;
                end else if (w_stop_edge) begin
                    w_next   = ST_ARMED;
                    w_reload = 1'b1;
                end else if (w_hit) begin
                    w_next = ST_RINGING;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // match_q resets high so a target equal to the reset clock cannot ring spuriously.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_target     <= '0;
            r_match      <= 1'b1;
            r_match_q    <= 1'b1;
            r_snooze_q   <= 1'b0;
            r_stop_q     <= 1'b0;
            r_snooze_cnt <= 2'd0;
            r_set_err    <= 1'b0;
        end else begin
            r_match    <= (w_cur == r_target);
            r_match_q  <= r_match;
            r_snooze_q <= i_snooze_btn;
            r_stop_q   <= i_stop_btn;
            r_set_err  <= w_load_try && !w_alm_valid;
            if (w_reload || w_load_ok) begin
                r_target     <= w_alm;
                r_snooze_cnt <= 2'd0;
            end else if (w_snooze_go) begin
                r_target     <= w_snz_time;
                r_snooze_cnt <= r_snooze_cnt + 2'd1;
            end else if (w_cnt_clr) begin
                r_snooze_cnt <= 2'd0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ring_sec <= 8'd0;
            r_blink    <= 16'd0;
            r_leds     <= LED_OFF;
        end else if (w_next == ST_RINGING && r_state != ST_RINGING) begin
            r_ring_sec <= 8'd0;
            r_blink    <= 16'd0;
            r_leds     <= LED_ON;
        end else if (w_next == ST_RINGING) begin
            if (i_sec_tick) begin
                r_ring_sec <= r_ring_sec + 8'd1;
            end
            if (r_blink == 16'(BLINK_CYC - 1)) begin
                r_blink <= 16'd0;
                r_leds  <= ~r_leds;
            end else begin
                r_blink <= r_blink + 16'd1;
            end
        end else begin
            r_ring_sec <= 8'd0;
            r_blink    <= 16'd0;
            r_leds     <= LED_OFF;
        end
    end

    assign o_state      = r_state;
    assign o_ringing    = (r_state == ST_RINGING);
    assign o_armed      = (r_state != ST_IDLE);
    assign o_leds       = r_leds;
    assign o_snooze_cnt = r_snooze_cnt;
    assign o_set_err    = r_set_err;

endmodule
